// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 8-digit common-anode seven-segment scan driver
// Optional blink support is compiled in when SEG7_BLINK_EN is defined.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic                    load_done,
  output logic                    frame_tick,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [DW-1:0]           div_q, div_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] stg_val_q, stg_val_d, shd_val_q, shd_val_d;
  logic [NUM_DIGITS-1:0]   stg_en_q, stg_en_d, shd_en_q, shd_en_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
  logic                    load_done_q, load_done_d;
  logic                    frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
`ifdef SEG7_BLINK_EN
  logic [NUM_DIGITS-1:0]   stg_blink_q, stg_blink_d, shd_blink_q, shd_blink_d;
  logic [5:0]              blink_cnt_q, blink_cnt_d;
  logic                    phase_q, phase_d;
`endif

  logic                    div_last;
  logic                    wrap;
  logic                    cur_en;
  logic [3:0]              nib;
  logic [6:0]              dec;
  logic [NUM_DIGITS-1:0]   sel;

  // Refresh divider and digit index; wrap marks the last cycle of a frame
  always_comb begin
    div_last = (div_q == DIV_LAST);
    wrap     = div_last && (idx_q == IDX_LAST);
    div_d    = div_last ? '0 : div_q + 1'b1;
    idx_d    = idx_q;
    if (div_last) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    frame_tick_d = wrap;
  end

  // Staging/shadow handoff: a new image only reaches the display at a frame boundary
  always_comb begin
    pending_d   = pending_q;
    stg_val_d   = stg_val_q;
    stg_en_d    = stg_en_q;
    stg_dp_d    = stg_dp_q;
    shd_val_d   = shd_val_q;
    shd_en_d    = shd_en_q;
    shd_dp_d    = shd_dp_q;
    load_done_d = 1'b0;
`ifdef SEG7_BLINK_EN
    stg_blink_d = stg_blink_q;
    shd_blink_d = shd_blink_q;
`endif
    if (wrap) begin
      // A load landing on the wrap cycle bypasses staging and goes straight to shadow
      if (load) begin
        shd_val_d = value_in;
        shd_en_d  = digit_en;
        shd_dp_d  = dp_in;
`ifdef SEG7_BLINK_EN
        shd_blink_d = blink_mask;
`endif
      end else if (pending_q) begin
        shd_val_d = stg_val_q;
        shd_en_d  = stg_en_q;
        shd_dp_d  = stg_dp_q;
`ifdef SEG7_BLINK_EN
        shd_blink_d = stg_blink_q;
`endif
      end
      load_done_d = load || pending_q;
      pending_d   = 1'b0;
    end else if (load) begin
      stg_val_d = value_in;
      stg_en_d  = digit_en;
      stg_dp_d  = dp_in;
`ifdef SEG7_BLINK_EN
      stg_blink_d = blink_mask;
`endif
      pending_d = 1'b1;
    end
  end

`ifdef SEG7_BLINK_EN
  // Blink phase flips after every 64 frames; phase 1 is the off phase
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (wrap) begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      if (blink_cnt_q == 6'd63) begin
        phase_d = ~phase_q;
      end
    end
  end
`endif

  // Output image for the current slot: anode select, hex decode and decimal point
  always_comb begin
`ifdef SEG7_BLINK_EN
    cur_en = shd_en_q[idx_q] && !(phase_q && shd_blink_q[idx_q]);
`else
    cur_en = shd_en_q[idx_q];
`endif
    nib = shd_val_q[{idx_q, 2'b00} +: 4];
    case (nib)
      4'h0:    dec = 7'b1000000;
      4'h1:    dec = 7'b1111001;
      4'h2:    dec = 7'b0100100;
      4'h3:    dec = 7'b0110000;
      4'h4:    dec = 7'b0011001;
      4'h5:    dec = 7'b0010010;
      4'h6:    dec = 7'b0000010;
      4'h7:    dec = 7'b1111000;
      4'h8:    dec = 7'b0000000;
      4'h9:    dec = 7'b0010000;
      4'hA:    dec = 7'b0001000;
      4'hB:    dec = 7'b0000011;
      4'hC:    dec = 7'b1000110;
      4'hD:    dec = 7'b0100001;
      4'hE:    dec = 7'b0000110;
      default: dec = 7'b0001110;
    endcase
    sel        = '0;
    sel[idx_q] = 1'b1;
    an_d  = cur_en ? ~sel : '1;
    seg_d = cur_en ? dec : 7'h7F;
    dp_d  = cur_en ? ~shd_dp_q[idx_q] : 1'b1;
  end

  // State register with asynchronous reset to a blank display
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q        <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      stg_val_q    <= '0;
      stg_en_q     <= '0;
      stg_dp_q     <= '0;
      shd_val_q    <= '0;
      shd_en_q     <= '0;
      shd_dp_q     <= '0;
      load_done_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
`ifdef SEG7_BLINK_EN
      stg_blink_q  <= '0;
      shd_blink_q  <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
`endif
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      stg_val_q    <= stg_val_d;
      stg_en_q     <= stg_en_d;
      stg_dp_q     <= stg_dp_d;
      shd_val_q    <= shd_val_d;
      shd_en_q     <= shd_en_d;
      shd_dp_q     <= shd_dp_d;
      load_done_q  <= load_done_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
`ifdef SEG7_BLINK_EN
      stg_blink_q  <= stg_blink_d;
      shd_blink_q  <= shd_blink_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
`endif
    end
  end

  assign load_done  = load_done_q;
  assign frame_tick = frame_tick_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed scoreboard bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int ND = 8;
  localparam int RD = 4;
  localparam int FRAME = ND * RD;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [31:0]   value_in = '0;
  logic [7:0]    digit_en = '0;
  logic [7:0]    dp_in = '0;
  logic          load_done;
  logic          frame_tick;
  logic [7:0]    an;
  logic [6:0]    seg;
  logic          dp;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            exp_ld = -1;
  bit            chk_blank = 1'b0;
  logic [6:0]    tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value_in   (value_in),
    .digit_en   (digit_en),
    .dp_in      (dp_in),
    .load_done  (load_done),
    .frame_tick (frame_tick),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s (cycle %0d): observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("load_done", 32'(load_done), 32'(cyc == exp_ld));
    chk("frame_tick", 32'(frame_tick), 32'(cyc % FRAME == 0));
    if (chk_blank) begin
      chk("blank_an", 32'(an), 32'hFF);
      chk("blank_seg", 32'(seg), 32'h7F);
      chk("blank_dp", 32'(dp), 32'h1);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] e, input logic [7:0] d);
    value_in = v;
    digit_en = e;
    dp_in    = d;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    value_in = $urandom;
    digit_en = 8'($urandom);
    dp_in    = 8'($urandom);
  endtask

  task automatic push_frame(input logic [31:0] v, input logic [7:0] e, input logic [7:0] d);
    exp_t x;
    for (int s = 0; s < ND; s++) begin
      logic [3:0] n;
      n = v[4*s +: 4];
      if (e[s]) begin
        x.an     = 8'hFF;
        x.an[s]  = 1'b0;
        x.seg    = tbl[n];
        x.dp     = ~d[s];
      end else begin
        x.an  = 8'hFF;
        x.seg = 7'h7F;
        x.dp  = 1'b1;
      end
      sb.push_back(x);
    end
  endtask

  task automatic check_frame(input int base);
    exp_t x;
    for (int s = 0; s < ND; s++) begin
      goto(base + RD * s + 2);
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      end else begin
        x = sb.pop_front();
        chk($sformatf("an_slot%0d", s), 32'(an), 32'(x.an));
        chk($sformatf("seg_slot%0d", s), 32'(seg), 32'(x.seg));
        chk($sformatf("dp_slot%0d", s), 32'(dp), 32'(x.dp));
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_load_done", 32'(load_done), 32'h0);
    chk("rst_frame_tick", 32'(frame_tick), 32'h0);

    // Idle after reset: blank display, frame_tick every 32 cycles
    chk_blank = 1'b1;
    repeat (100) tick();
    chk_blank = 1'b0;

    // Mid-frame load, shown from the next frame boundary
    goto(112);
    exp_ld = 128;
    do_load(32'h0123ABCF, 8'hFF, 8'h01);
    push_frame(32'h0123ABCF, 8'hFF, 8'h01);
    check_frame(128);

    // Two loads in one frame: one load_done, last image wins
    goto(165);
    exp_ld = 192;
    do_load(32'h11111111, 8'hFF, 8'h00);
    goto(175);
    do_load(32'h22222222, 8'hFF, 8'h00);
    push_frame(32'h22222222, 8'hFF, 8'h00);
    check_frame(192);

    // Load on the wrap cycle goes straight to the display
    goto(FRAME * 8 - 1);
    exp_ld = FRAME * 8;
    do_load(32'h55555555, 8'hFF, 8'h00);
    push_frame(32'h55555555, 8'hFF, 8'h00);
    check_frame(FRAME * 8);

    // Alternate digits blanked
    goto(290);
    exp_ld = 320;
    do_load(32'h89ABCDEF, 8'b10101010, 8'hAA);
    push_frame(32'h89ABCDEF, 8'b10101010, 8'hAA);
    check_frame(320);

    // Asynchronous reset with a load pending
    goto(360);
    do_load(32'h76543210, 8'hFF, 8'hFF);
    goto(374);
    chk("pre_reset_an", 32'(an), 32'hDF);
    reset = 1'b1;
    #1;
    chk("async_rst_an", 32'(an), 32'hFF);
    chk("async_rst_seg", 32'(seg), 32'h7F);
    chk("async_rst_dp", 32'(dp), 32'h1);
    chk("async_rst_load_done", 32'(load_done), 32'h0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    cyc       = 0;
    exp_ld    = -1;
    chk_blank = 1'b1;
    repeat (80) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for the Nexys A7 8-digit common-anode seven-segment display. It shows hex values produced by the binary conversion game logic.
- Caller hands over a new display image with a one-cycle `load` strobe.
- The block captures the image and applies it only at a frame boundary, so a partial image is never shown.
- It then scans the digits continuously with active-low anode, segment and dp outputs.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (1..8).
- REFRESH_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz). Must be >= 2.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high.
- load  in  1  one-cycle strobe; capture value_in, digit_en and dp_in.
- value_in  in  4*NUM_DIGITS  hex nibble per digit; digit k = bits [4k+3:4k]; digit 0 is rightmost.
- digit_en  in  NUM_DIGITS  1 = digit shown, 0 = digit blanked.
- dp_in  in  NUM_DIGITS  1 = decimal point lit.
- load_done  out  1  one-cycle pulse when the captured image becomes the displayed image.
- frame_tick  out  1  one-cycle pulse each time the digit index wraps to 0.
- an  out  NUM_DIGITS  anode enables, active-low.
- seg  out  7  segments, active-low; seg[6:0] = {CG,CF,CE,CD,CC,CB,CA}.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset values: an all 1s, seg 7'h7F, dp 1, load_done 0, frame_tick 0. Divider 0, digit index 0, pending 0, staging and shadow registers 0. With the shadow digit_en at 0, all digits are blanked after reset.
- Divider: counts 0..REFRESH_DIV-1. At terminal count:
  - divider returns to 0;
  - index advances by 1;
  - index NUM_DIGITS-1 wraps to 0 (this is the wrap event).
- frame_tick: asserted the cycle after a wrap event.
- Load capture: on `load`, value_in, digit_en and dp_in are latched into staging registers and pending is set. The source does not need to hold its values after the strobe.
- Repeated loads: a load while pending is already set overwrites staging. Only one load_done is produced, for the last image.
- Shadow update: on a wrap event with pending=1, shadow takes staging, pending clears, and load_done pulses the next cycle (coincident with frame_tick).
- Load on the wrap cycle: if load and the wrap event occur in the same cycle, shadow takes value_in directly from that cycle, pending stays 0, and load_done pulses the next cycle.
- Output registration: an, seg and dp are registered from shadow at the current index. Outputs change 1 cycle after the index changes.
  - an: only bit[index] is 0, and only if shadow digit_en[index]=1; otherwise an is all 1s.
  - dp: equals ~shadow dp_in[index] when the digit is enabled; 1 when blanked.
- Decode (active-low {G..A}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Blanked digit: seg = 1111111.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). Any pending load is discarded and no load_done is issued.

Optional Feature:
Macro SEG7_BLINK_EN.
- Defined:
  - adds input blink_mask[NUM_DIGITS-1:0];
  - adds a free-running blink counter that toggles a phase bit every 64 frame_ticks (about 1 Hz on/off at defaults);
  - blink_mask is captured and shadowed exactly like digit_en;
  - during the off phase, digits whose shadow blink_mask bit is set are blanked (an bit 1, seg 1111111, dp 1);
  - blink counter and phase reset to 0, which is the on phase.
- Undefined: no blink_mask port and no blink logic; behaviour is exactly as above.

Test Plan:
Bench uses REFRESH_DIV=4 and NUM_DIGITS=8, so one frame is 32 cycles.
- Reset release, no load: for 100 cycles an=8'hFF, seg=7'h7F, dp=1; frame_tick pulses every 32 cycles.
- Load value_in=32'h0123ABCF, digit_en=8'hFF, dp_in=8'h01 at mid-frame:
  - load_done 0 until the wrap, then a single pulse with frame_tick;
  - next frame, slot 0 gives an=8'hFE, seg=0001110 (F), dp=0;
  - slot 7 gives an=8'h7F, seg=1000000 (0), dp=1.
- Two loads in one frame (32'h11111111, then 32'h22222222): exactly one load_done; every digit then shows seg=0100100.
- Load asserted on the wrap cycle with 32'h55555555: load_done the next cycle; the new frame shows 0010010 on all digits with no old-image slot.
- digit_en=8'b10101010: in slots 0, 2, 4, 6 an=8'hFF and seg=7'h7F; odd slots are driven normally.
- Reset asserted while pending=1: outputs return to reset values at once; after release, no load_done ever appears and the display stays blank.
